// File: rtl/pcap_replay_pkg.sv
// Shared types and helpers for the pcap replay output path.
// tuser layout is documented here so every stage agrees on field positions.
package pcap_replay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_MSB = 15;
    localparam int TUSER_SRC_LSB = 16;
    localparam int TUSER_SRC_MSB = 23;
    localparam int TUSER_DST_LSB = 24;
    localparam int TUSER_DST_MSB = 31;

    // Widest tkeep any instance may use; narrower buses are zero-extended.
    localparam int TKEEP_MAX_W = 128;
    localparam int POPCNT_W    = $clog2(TKEEP_MAX_W + 1);

    function automatic logic [POPCNT_W-1:0] popcount(input logic [TKEEP_MAX_W-1:0] v);
        logic [POPCNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < TKEEP_MAX_W; i++) begin
            c = c + {{(POPCNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pcap_replay_ipg_shaper.sv
// Enforces a minimum idle gap between replayed packets and counts traffic.
// Zero latency; tready passes straight through, both directions closed while gapping or disabled.
module pcap_replay_ipg_shaper
    import pcap_replay_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int IPG_WIDTH          = 32,
    parameter int PKT_CNT_WIDTH      = 32,
    parameter int BYTE_CNT_WIDTH     = 48
) (
    input  logic                              axis_aclk,
    input  logic                              axis_areset,
    input  logic                              sw_rst,
    input  logic                              en,
    input  logic [IPG_WIDTH-1:0]              ipg_cycles,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [PKT_CNT_WIDTH-1:0]          pkt_count,
    output logic [BYTE_CNT_WIDTH-1:0]         byte_count,
    output logic                              busy
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam logic [IPG_WIDTH-1:0]     GAP_ONE = IPG_WIDTH'(1);
    localparam logic [PKT_CNT_WIDTH-1:0] PKT_ONE = PKT_CNT_WIDTH'(1);

    state_t                   state;
    state_t                   state_nxt;
    logic [IPG_WIDTH-1:0]     gap_cnt;
    logic [IPG_WIDTH-1:0]     gap_cnt_nxt;
    logic                     skip_gap;
    logic                     skip_gap_nxt;

    logic                     gate_open;
    logic                     hs;
    logic                     eop_hs;
    logic [TKEEP_MAX_W-1:0]   keep_ext;
    logic [POPCNT_W-1:0]      beat_bytes;
    logic [BYTE_CNT_WIDTH:0]  byte_sum;

    // Gate depends only on state, enable and reset so tvalid never waits on tready.
    always_comb begin
        gate_open = 1'b0;
        if (!axis_areset) begin
            case (state)
                ST_IDLE: gate_open = en;
                ST_PASS: gate_open = 1'b1;
                default: gate_open = 1'b0;
            endcase
        end
    end

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid & gate_open;
    assign s_axis_tready = m_axis_tready & gate_open;

    assign hs     = s_axis_tvalid & m_axis_tready & gate_open;
    assign eop_hs = hs & s_axis_tlast;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            skip_gap <= 1'b0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_cnt_nxt;
            skip_gap <= skip_gap_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gap_cnt_nxt  = gap_cnt;
        skip_gap_nxt = skip_gap;

        case (state)
            ST_IDLE: begin
                if (hs && !s_axis_tlast) begin
                    state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                // A soft reset mid-packet lets the packet finish but drops its trailing gap.
                if (sw_rst) begin
                    skip_gap_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                gap_cnt_nxt = gap_cnt - GAP_ONE;
                if (sw_rst || gap_cnt <= GAP_ONE) begin
                    state_nxt   = ST_IDLE;
                    gap_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                gap_cnt_nxt = '0;
            end
        endcase

        // The gap length is latched at the tlast handshake; later edits wait for the next packet.
        if (eop_hs) begin
            skip_gap_nxt = 1'b0;
            if (sw_rst || skip_gap || ipg_cycles == '0) begin
                state_nxt   = ST_IDLE;
                gap_cnt_nxt = '0;
            end else begin
                state_nxt   = ST_GAP;
                gap_cnt_nxt = ipg_cycles;
            end
        end
    end

    always_comb begin
        keep_ext             = '0;
        keep_ext[KEEP_W-1:0] = s_axis_tkeep;
    end

    assign beat_bytes = popcount(keep_ext);
    assign byte_sum   = {1'b0, byte_count} + (BYTE_CNT_WIDTH+1)'(beat_bytes);

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else if (sw_rst) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else if (hs) begin
            byte_count <= byte_sum[BYTE_CNT_WIDTH] ? '1 : byte_sum[BYTE_CNT_WIDTH-1:0];
            if (s_axis_tlast && !(&pkt_count)) begin
                pkt_count <= pkt_count + PKT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pcap_replay_ipg_shaper.sv
// Directed bench: a cycle-timestamp model predicts every output each cycle, and
// literal expectations pin packet timing, data order and counter values.
module tb_pcap_replay_ipg_shaper;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam longint unsigned BYTE_MAX = (64'd1 << 48) - 1;
    localparam longint unsigned PKT_MAX  = (64'd1 << 32) - 1;

    logic            axis_aclk;
    logic            axis_areset;
    logic            sw_rst;
    logic            en;
    logic [31:0]     ipg_cycles;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [31:0]     pkt_count;
    logic [47:0]     byte_count;
    logic            busy;

    pcap_replay_ipg_shaper dut (
        .axis_aclk     (axis_aclk),
        .axis_areset   (axis_areset),
        .sw_rst        (sw_rst),
        .en            (en),
        .ipg_cycles    (ipg_cycles),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count),
        .byte_count    (byte_count),
        .busy          (busy)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: a packet may start once the current cycle reaches next_start.
    bit              m_in_pkt;
    bit              m_skip;
    longint          m_next_start;
    longint unsigned m_pkt;
    longint unsigned m_bytes;
    bit              obs_in;

    int            sop_q[$];
    int            eop_q[$];
    logic [DW-1:0] dat_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge axis_aclk) begin : cmp
        bit open_m;
        bit hs_m;
        bit was_in;
        longint unsigned pc;
        if (axis_areset) begin
            m_in_pkt     = 0;
            m_skip       = 0;
            m_next_start = 0;
            m_pkt        = 0;
            m_bytes      = 0;
            obs_in       = 0;
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_s_tready", s_axis_tready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pkt_count", pkt_count, 0);
            chk("rst_byte_count", byte_count, 0);
        end else begin
            open_m = m_in_pkt || (en && (cyc >= m_next_start));
            chk("m_tvalid", m_axis_tvalid, s_axis_tvalid && open_m);
            chk("s_tready", s_axis_tready, m_axis_tready && open_m);
            chk("busy", busy, m_in_pkt || (cyc < m_next_start));
            chk("pkt_count", pkt_count, m_pkt);
            chk("byte_count", byte_count, m_bytes);
            chk("tdata_pass", m_axis_tdata, s_axis_tdata);
            chk("tuser_pass", m_axis_tuser, s_axis_tuser);
            chk("tlast_tkeep_pass", {m_axis_tlast, m_axis_tkeep}, {s_axis_tlast, s_axis_tkeep});

            if (m_axis_tvalid && m_axis_tready) begin
                if (!obs_in) sop_q.push_back(cyc);
                dat_q.push_back(m_axis_tdata);
                if (m_axis_tlast) begin
                    eop_q.push_back(cyc);
                    obs_in = 0;
                end else begin
                    obs_in = 1;
                end
            end

            hs_m   = s_axis_tvalid && m_axis_tready && open_m;
            was_in = m_in_pkt;
            if (sw_rst) begin
                m_pkt   = 0;
                m_bytes = 0;
            end else if (hs_m) begin
                pc      = $countones(s_axis_tkeep);
                m_bytes = (m_bytes + pc > BYTE_MAX) ? BYTE_MAX : m_bytes + pc;
                if (s_axis_tlast && m_pkt < PKT_MAX) m_pkt = m_pkt + 1;
            end

            if (hs_m && s_axis_tlast) begin
                m_in_pkt = 0;
                if (sw_rst || m_skip || ipg_cycles == 0) m_next_start = cyc + 1;
                else m_next_start = cyc + 1 + longint'(ipg_cycles);
                m_skip = 0;
            end else begin
                if (hs_m) m_in_pkt = 1;
                if (sw_rst && was_in) m_skip = 1;
                if (sw_rst && !was_in && cyc < m_next_start) m_next_start = cyc + 1;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge axis_aclk);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [7:0] tag, input int b);
        return {8{tag, 8'(b), 16'hA5C3}};
    endfunction

    task automatic drive_pkt(input int nb, input logic [KW-1:0] klast, input logic [7:0] tag);
        bit acc;
        int t;
        for (int b = 0; b < nb; b++) begin
            acc = 0;
            t   = 0;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tkeep  = (b == nb - 1) ? klast : '1;
            s_axis_tdata  = beat_data(tag, b);
            s_axis_tuser  = {4{tag, 24'h00_0040}};
            while (!acc && t < 200) begin
                @(negedge axis_aclk);
                acc = s_axis_tready;
                @(posedge axis_aclk);
                #1;
                t++;
            end
            if (!acc) begin
                n_vec++;
                n_err++;
                $display("FAIL drive_timeout: beat %0d of packet %0h not accepted in %0d cycles, expected acceptance", b, tag, t);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic soft_clear();
        sw_rst = 1'b1;
        step(1);
        sw_rst = 1'b0;
        sop_q.delete();
        eop_q.delete();
        dat_q.delete();
        step(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [4:0] pat;
        int en_cyc;
        int sw_cyc;

        axis_areset   = 1'b1;
        sw_rst        = 1'b0;
        en            = 1'b1;
        ipg_cycles    = 0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;

        // Reset holds the stream closed even with valid, ready and en all high.
        step(3);
        chk("reset_m_tvalid", m_axis_tvalid, 0);
        chk("reset_s_tready", s_axis_tready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_byte_count", byte_count, 0);
        s_axis_tvalid = 1'b0;
        axis_areset   = 1'b0;
        step(2);

        // Back-to-back with zero gap.
        ipg_cycles = 0;
        drive_pkt(3, '1, 8'h11);
        drive_pkt(3, '1, 8'h12);
        chk("b2b_pkt_count", pkt_count, 2);
        chk("b2b_byte_count", byte_count, 192);
        chk("b2b_beats", dat_q.size(), 6);
        chk("b2b_span", eop_q[1] - sop_q[0], 5);

        // Gap of 5: next start lands at tlast + 6.
        soft_clear();
        ipg_cycles = 5;
        drive_pkt(2, '1, 8'h21);
        drive_pkt(2, '1, 8'h22);
        chk("ipg5_spacing", sop_q[1] - eop_q[0], 6);
        chk("ipg5_byte_count", byte_count, 128);

        // Downstream stalls inside a packet.
        soft_clear();
        ipg_cycles = 2;
        pat = 5'b11001;
        fork
            drive_pkt(4, '1, 8'h31);
            begin
                for (int i = 0; i < 5; i++) begin
                    m_axis_tready = pat[i];
                    step(1);
                end
                m_axis_tready = 1'b1;
            end
        join
        chk("stall_beats", dat_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("stall_data_order", dat_q[i], beat_data(8'h31, i));
        chk("stall_span", eop_q[0] - sop_q[0], 5);
        step(4);

        // Enable dropped mid-packet: packet finishes, next start waits for en.
        soft_clear();
        ipg_cycles = 0;
        fork
            drive_pkt(3, '1, 8'h41);
            begin
                step(1);
                en = 1'b0;
            end
        join
        en_cyc = 0;
        fork
            drive_pkt(1, '1, 8'h42);
            begin
                step(4);
                en     = 1'b1;
                en_cyc = cyc;
            end
        join
        chk("en_pkt_complete", eop_q[0] - sop_q[0], 2);
        chk("en_start_same_cycle", sop_q[1], en_cyc);

        // Soft reset during a long gap.
        soft_clear();
        ipg_cycles = 100;
        drive_pkt(1, '1, 8'h51);
        step(8);
        sw_rst = 1'b1;
        sw_cyc = cyc;
        step(1);
        sw_rst = 1'b0;
        chk("swrst_gap_pkt_count", pkt_count, 0);
        chk("swrst_gap_byte_count", byte_count, 0);
        chk("swrst_gap_busy", busy, 0);
        ipg_cycles = 0;
        drive_pkt(2, '1, 8'h52);
        chk("swrst_gap_restart", sop_q[1], sw_cyc + 1);

        // Soft reset mid-packet: no gap after it, beat on the reset cycle uncounted.
        ipg_cycles = 100;
        fork
            drive_pkt(4, '1, 8'h53);
            begin
                step(2);
                sw_rst = 1'b1;
                step(1);
                sw_rst = 1'b0;
            end
        join
        ipg_cycles = 0;
        drive_pkt(1, '1, 8'h54);
        chk("swrst_pass_no_gap", sop_q[3], eop_q[2] + 1);
        chk("swrst_pass_pkt_count", pkt_count, 2);
        chk("swrst_pass_byte_count", byte_count, 64);

        // Asynchronous reset in the middle of a packet.
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '1;
        step(2);
        axis_areset = 1'b1;
        #1;
        chk("arst_m_tvalid", m_axis_tvalid, 0);
        chk("arst_s_tready", s_axis_tready, 0);
        chk("arst_pkt_count", pkt_count, 0);
        chk("arst_byte_count", byte_count, 0);
        s_axis_tvalid = 1'b0;
        step(2);
        axis_areset = 1'b0;
        step(1);
        drive_pkt(1, 32'h0000_FFFF, 8'h61);
        chk("post_arst_byte_count", byte_count, 16);
        chk("post_arst_pkt_count", pkt_count, 1);

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcap_replay_ipg_shaper.md
Name: pcap_replay_ipg_shaper

Overview:
- Per-port stage directly downstream of the external-memory replay engine. It consumes one replayed AXI4-Stream port and forwards it unchanged.
- Enforces a software-programmed minimum inter-packet gap in clock cycles. The gap counts from each tlast handshake.
- Gates packet starts with an enable and keeps saturating packet and byte counters for the register block.
- One instance per output queue, placed between the replay engine and the output arbiter/MAC path.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width (tkeep = C_AXIS_DATA_WIDTH/8).
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- IPG_WIDTH, 32, width of the gap setting.
- PKT_CNT_WIDTH, 32, packet counter width.
- BYTE_CNT_WIDTH, 48, byte counter width.

Ports:
- axis_aclk  in  1  sole clock.
- axis_areset  in  1  asynchronous reset, active-high.
- sw_rst  in  1  synchronous soft reset from register block.
- en  in  1  allow new packet starts.
- ipg_cycles  in  IPG_WIDTH  minimum idle cycles between packets.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per parameters  stream from replay engine.
- s_axis_tready  out  1  ready to replay engine.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per parameters  stream to downstream.
- m_axis_tready  in  1  downstream ready.
- pkt_count  out  PKT_CNT_WIDTH  packets forwarded, saturating.
- byte_count  out  BYTE_CNT_WIDTH  bytes forwarded (sum of tkeep popcount), saturating.
- busy  out  1  high in PASS or GAP.

Behaviour:
- Datapath is zero-latency combinational pass-through.
  - m_axis_tdata/tkeep/tuser/tlast = s_axis_*.
  - m_axis_tvalid = s_axis_tvalid & open.
  - s_axis_tready = m_axis_tready & open.
  - Handshake hs = s_axis_tvalid & m_axis_tready & open.
- "open" is decoded from the state and is independent of m_axis_tready. tvalid therefore never depends on tready (AXIS compliant).
- States:
  - IDLE: open = en. On hs with tlast=0 -> PASS. On hs with tlast=1 (single-beat packet), apply the tlast rule below.
  - PASS: open = 1. On hs with tlast=1, apply the tlast rule.
  - GAP: open = 0. gap_cnt decrements every cycle. When gap_cnt==1 -> IDLE.
- tlast rule: sample ipg_cycles at the tlast handshake. If 0 -> IDLE; else -> GAP with gap_cnt = ipg_cycles.
- Timing: tlast hs in cycle T gives the earliest next first-beat hs at T+1+ipg_cycles. With ipg=0, packets may be back-to-back.
- en low: blocks only new packet starts in IDLE. A packet in PASS always completes; no truncation.
- ipg_cycles changes mid-GAP: no effect until the next tlast.
- sw_rst (synchronous, one cycle):
  - Clears pkt_count and byte_count.
  - GAP -> IDLE next cycle.
  - PASS: continues until tlast, then -> IDLE, skipping that gap. A pending-skip flag is set by sw_rst in PASS and cleared at tlast.
  - Same-cycle tlast hs and sw_rst: counters clear and do not count that packet; next state IDLE.
- Counters:
  - pkt_count +1 on each tlast hs.
  - byte_count += popcount(s_axis_tkeep) on every hs.
  - Both saturate at all-ones.
- Asynchronous reset: state IDLE, gap_cnt 0, skip flag 0, counters 0, busy 0. While axis_areset is high, m_axis_tvalid and s_axis_tready are forced 0.
- busy = (state != IDLE).

Decomposition:
- Shared package pcap_replay_pkg:
  - State encoding constants ST_IDLE/ST_PASS/ST_GAP.
  - Tuser field offsets (length [15:0], src port [23:16], dst port [31:24]); carried unmodified here.
  - A popcount function sized by the tkeep width.
- No sub-module needed; state machine, gap counter and statistics sit in one module.

Test Plan:
- ipg=0, en=1, m_tready=1, two 3-beat packets driven back-to-back -> 6 consecutive output beats, pkt_count=2, byte_count=192 (full tkeep).
- ipg=5, two 2-beat packets -> pkt1 tlast hs at cycle T, s_axis_tready=0 for T+1..T+5, pkt2 first beat hs at T+6, busy=1 through T+5.
- m_tready pattern 1,0,0,1,1 during a 4-beat packet -> all beats delivered once, in order, data unchanged; gap counted from the actual tlast hs.
- en dropped after beat 1 of a 3-beat packet -> packet completes; next packet (tvalid held) not accepted until en=1, then accepted the same cycle.
- ipg=100, sw_rst pulsed in GAP at cycle 10 -> IDLE at 11, counters 0, next packet accepted at 11. sw_rst mid-PASS -> packet completes, no gap follows.
- axis_areset asserted mid-packet -> m_axis_tvalid=0 immediately, counters 0. After release, a single beat with tkeep=0x0000FFFF and tlast -> byte_count=16, pkt_count=1.
